// File: rtl/enemy_shot.sv
// rtl/enemy_shot.sv - falling enemy shot: cooldown/launch/fall FSM plus pixel renderer (optional SHOT_LFSR_DELAY_EN)
module enemy_shot #(
    parameter int unsigned STEP_DIV  = 200000,
    parameter int unsigned STEP_PX   = 2,
    parameter int unsigned COOLDOWN  = 25000000,
    parameter int unsigned Y_BOTTOM  = 520,
    parameter int unsigned SHOT_XOFF = 10,
    parameter int unsigned SHOT_W    = 2,
    parameter int unsigned SHOT_H    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic        shooter_valid,
    input  logic [10:0] shooter_x,
    input  logic [10:0] shooter_y,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic [10:0] posX_shot,
    output logic [10:0] posY_shot,
    output logic        shot_active,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    typedef enum logic {S_COOLDOWN, S_FALL} state_t;

    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    state_t        state, state_n;
    logic [25:0]   cool_cnt, cool_n, reload;
    logic [SW-1:0] step_cnt, step_n;
    logic [10:0]   pos_x_n, pos_y_n;
    logic          active_n;
    logic [11:0]   y_stepped;
    logic [11:0]   h_ext, v_ext;
    logic          lit;

`ifdef SHOT_LFSR_DELAY_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) randomising the cooldown length
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign reload = 26'(COOLDOWN) + 26'({lfsr[7:0], 16'h0000});
`else
    assign reload = 26'(COOLDOWN);
`endif

    // 12-bit sum so a step past the bottom can never wrap back on screen
    assign y_stepped = {1'b0, posY_shot} + 12'(STEP_PX);

    // Next-state and datapath: count down, launch, fall, retire; freeze holds everything
    always_comb begin
        state_n  = state;
        cool_n   = cool_cnt;
        step_n   = step_cnt;
        pos_x_n  = posX_shot;
        pos_y_n  = posY_shot;
        active_n = shot_active;
        case (state)
            S_COOLDOWN: begin
                if (!freeze) begin
                    if (cool_cnt != 26'd0) begin
                        cool_n = cool_cnt - 26'd1;
                    end else if (shooter_valid) begin
                        pos_x_n  = shooter_x + 11'(SHOT_XOFF);
                        pos_y_n  = shooter_y;
                        active_n = 1'b1;
                        step_n   = '0;
                        state_n  = S_FALL;
                    end
                end
            end
            S_FALL: begin
                if (!freeze) begin
                    if (step_cnt == STEP_LAST) begin
                        step_n = '0;
                        if (y_stepped >= 12'(Y_BOTTOM)) begin
                            active_n = 1'b0;
                            pos_x_n  = 11'd0;
                            pos_y_n  = 11'd0;
                            cool_n   = reload;
                            state_n  = S_COOLDOWN;
                        end else begin
                            pos_y_n = y_stepped[10:0];
                        end
                    end else begin
                        step_n = step_cnt + SW'(1);
                    end
                end
            end
            default: state_n = S_COOLDOWN;
        endcase
    end

    // State and shot registers; reset overrides freeze and every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_COOLDOWN;
            cool_cnt    <= reload;
            step_cnt    <= '0;
            posX_shot   <= 11'd0;
            posY_shot   <= 11'd0;
            shot_active <= 1'b0;
        end else begin
            state       <= state_n;
            cool_cnt    <= cool_n;
            step_cnt    <= step_n;
            posX_shot   <= pos_x_n;
            posY_shot   <= pos_y_n;
            shot_active <= active_n;
        end
    end

    assign h_ext = {2'b00, h_counter};
    assign v_ext = {2'b00, v_counter};
    assign lit = shot_active
              && (h_ext >= {1'b0, posX_shot})
              && (h_ext <  {1'b0, posX_shot} + 12'(SHOT_W))
              && (v_ext >= {1'b0, posY_shot})
              && (v_ext <  {1'b0, posY_shot} + 12'(SHOT_H));

    // Registered pixel colour: red where the shot is, black elsewhere
    always_ff @(posedge clk) begin
        if (reset) begin
            R <= 8'h00;
            G <= 8'h00;
            B <= 8'h00;
        end else begin
            R <= lit ? 8'hFF : 8'h00;
            G <= 8'h00;
            B <= 8'h00;
        end
    end

endmodule

// File: tb/tb_enemy_shot.sv
// tb/tb_enemy_shot.sv - self-checking bench for enemy_shot
module tb_enemy_shot;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic        shooter_valid;
    logic [10:0] shooter_x;
    logic [10:0] shooter_y;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic [10:0] posX_shot;
    logic [10:0] posY_shot;
    logic        shot_active;
    logic [7:0]  R, G, B;

    int checks = 0;
    int errors = 0;

    enemy_shot #(
        .STEP_DIV (4),
        .STEP_PX  (2),
        .COOLDOWN (10),
        .Y_BOTTOM (40),
        .SHOT_XOFF(10),
        .SHOT_W   (2),
        .SHOT_H   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .shooter_valid(shooter_valid),
        .shooter_x    (shooter_x),
        .shooter_y    (shooter_y),
        .h_counter    (h_counter),
        .v_counter    (v_counter),
        .posX_shot    (posX_shot),
        .posY_shot    (posY_shot),
        .shot_active  (shot_active),
        .R            (R),
        .G            (G),
        .B            (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] sx;
        logic [10:0] sy;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [7:0]  er;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reset, release with a valid shooter, and confirm launch on the 11th edge
    task automatic launch_at(input logic [10:0] sx, input logic [10:0] sy);
        reset         = 1'b1;
        freeze        = 1'b0;
        shooter_valid = 1'b1;
        shooter_x     = sx;
        shooter_y     = sy;
        tick(1);
        reset = 1'b0;
        tick(10);
        check("pre_launch_inactive", shot_active, 0);
        tick(1);
        check("launch_active", shot_active, 1);
    endtask

    initial begin
        vecs[0] = '{sx: 300,  sy: 20, h: 311,  v: 22, ex: 310,  ey: 20, er: 8'hFF};
        vecs[1] = '{sx: 300,  sy: 20, h: 312,  v: 22, ex: 310,  ey: 20, er: 8'h00};
        vecs[2] = '{sx: 300,  sy: 20, h: 310,  v: 20, ex: 310,  ey: 20, er: 8'hFF};
        vecs[3] = '{sx: 300,  sy: 20, h: 309,  v: 20, ex: 310,  ey: 20, er: 8'h00};
        vecs[4] = '{sx: 300,  sy: 20, h: 311,  v: 27, ex: 310,  ey: 20, er: 8'hFF};
        vecs[5] = '{sx: 300,  sy: 20, h: 311,  v: 28, ex: 310,  ey: 20, er: 8'h00};
        vecs[6] = '{sx: 0,    sy: 0,  h: 10,   v: 0,  ex: 10,   ey: 0,  er: 8'hFF};
        vecs[7] = '{sx: 0,    sy: 0,  h: 9,    v: 7,  ex: 10,   ey: 0,  er: 8'h00};
        vecs[8] = '{sx: 5,    sy: 36, h: 16,   v: 43, ex: 15,   ey: 36, er: 8'hFF};
        vecs[9] = '{sx: 1000, sy: 30, h: 1011, v: 37, ex: 1010, ey: 30, er: 8'hFF};

        reset         = 1'b1;
        freeze        = 1'b0;
        shooter_valid = 1'b0;
        shooter_x     = 11'd0;
        shooter_y     = 11'd0;
        h_counter     = 10'd0;
        v_counter     = 10'd0;
        tick(2);
        check("reset_active", shot_active, 0);
        check("reset_posx", posX_shot, 0);
        check("reset_posy", posY_shot, 0);
        check("reset_r_inactive_at_origin", R, 8'h00);

        // Launch position and pixel rendering, shot held in place by freeze
        for (int i = 0; i < 10; i++) begin
            launch_at(vecs[i].sx, vecs[i].sy);
            freeze    = 1'b1;
            h_counter = vecs[i].h;
            v_counter = vecs[i].v;
            tick(1);
            check($sformatf("vec%0d_posx", i), posX_shot, vecs[i].ex);
            check($sformatf("vec%0d_posy", i), posY_shot, vecs[i].ey);
            check($sformatf("vec%0d_r", i), R, vecs[i].er);
            check($sformatf("vec%0d_g", i), G, 8'h00);
            check($sformatf("vec%0d_b", i), B, 8'h00);
        end
        freeze    = 1'b0;
        h_counter = 10'd0;
        v_counter = 10'd0;

        // Fall, shooter movement ignored, retire at bottom, relaunch after cooldown
        launch_at(11'd300, 11'd20);
        check("fall_launch_x", posX_shot, 310);
        check("fall_launch_y", posY_shot, 20);
        tick(3);
        check("fall_no_step_yet", posY_shot, 20);
        tick(1);
        check("fall_first_step", posY_shot, 22);
        shooter_x = 11'd5;
        shooter_y = 11'd100;
        for (int k = 2; k <= 9; k++) begin
            tick(4);
            check($sformatf("fall_step%0d_y", k), posY_shot, 20 + 2 * k);
            check($sformatf("fall_step%0d_x", k), posX_shot, 310);
        end
        tick(4);
        check("retire_active", shot_active, 0);
        check("retire_x", posX_shot, 0);
        check("retire_y", posY_shot, 0);
        tick(10);
        check("relaunch_wait", shot_active, 0);
        tick(1);
        check("relaunch_active", shot_active, 1);
        check("relaunch_x", posX_shot, 15);
        check("relaunch_y", posY_shot, 100);

        // Freeze mid-fall holds position and step count
        launch_at(11'd300, 11'd20);
        tick(12);
        check("freeze_start_y", posY_shot, 26);
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check($sformatf("freeze_hold_y_%0d", i), posY_shot, 26);
        end
        check("freeze_hold_active", shot_active, 1);
        freeze = 1'b0;
        tick(3);
        check("unfreeze_before_step", posY_shot, 26);
        tick(1);
        check("unfreeze_step", posY_shot, 28);

        // No launch while shooter_valid is low
        reset         = 1'b1;
        shooter_valid = 1'b0;
        shooter_x     = 11'd300;
        shooter_y     = 11'd20;
        tick(1);
        reset = 1'b0;
        tick(30);
        check("invalid_no_launch", shot_active, 0);
        shooter_valid = 1'b1;
        tick(1);
        check("valid_launch", shot_active, 1);
        check("valid_launch_x", posX_shot, 310);

        // Reset pulse mid-fall
        launch_at(11'd300, 11'd20);
        h_counter = 10'd311;
        v_counter = 10'd32;
        tick(20);
        check("midfall_y", posY_shot, 30);
        check("midfall_r_lit", R, 8'hFF);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_active", shot_active, 0);
        check("midreset_x", posX_shot, 0);
        check("midreset_y", posY_shot, 0);
        check("midreset_r", R, 8'h00);
        check("midreset_g", G, 8'h00);
        check("midreset_b", B, 8'h00);
        tick(10);
        check("midreset_wait", shot_active, 0);
        tick(1);
        check("midreset_relaunch", shot_active, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
